// File: rtl/fractal_sync_root_rsp.sv
`default_nettype none
// ============================================================================
// Module   : fractal_sync_root_rsp
// Brief    : Root of the fractal sync tree. Pairs barrier requests from the
//            two subtrees and returns wake/error responses through per-port
//            FIFOs.
// Revision : 1.0
// ============================================================================
module fractal_sync_root_rsp #(
    parameter int  AGGREGATE_WIDTH = 6,
    parameter int  ID_WIDTH        = 5,
    parameter int  SRC_WIDTH       = 4,
    parameter int  N_BARRIERS      = 8,
    parameter int  FIFO_DEPTH      = 4,
    parameter type fsync_req_t     = struct packed {
        logic                       sync;
        logic [AGGREGATE_WIDTH-1:0] aggr;
        logic [ID_WIDTH-1:0]        id_req;
        logic [SRC_WIDTH-1:0]       src;
    },
    parameter type fsync_rsp_t     = struct packed {
        logic                 wake;
        logic [SRC_WIDTH-1:0] dst;
        logic                 error;
    }
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  fsync_req_t req_i [2],
    output fsync_rsp_t rsp_o [2],
    output logic [1:0] overflow_o
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef logic [SRC_WIDTH-1:0] src_t;
    typedef struct packed {
        src_t dst;
        logic error;
    } ent_t;

    logic [1:0]    arr_q [N_BARRIERS];
    logic [1:0]    arr_d [N_BARRIERS];
    src_t          src_q [N_BARRIERS][2];
    src_t          src_d [N_BARRIERS][2];
    ent_t          mem_q [2][FIFO_DEPTH];
    ent_t          mem_d [2][FIFO_DEPTH];
    logic [PW-1:0] wr_q [2];
    logic [PW-1:0] wr_d [2];
    logic [PW-1:0] rd_q [2];
    logic [PW-1:0] rd_d [2];
    logic [CW-1:0] cnt_q [2];
    logic [CW-1:0] cnt_d [2];
    logic [1:0]    wake_q, wake_d;
    ent_t          out_q [2];
    ent_t          out_d [2];
    logic [1:0]    ovf_q, ovf_d;

    logic [1:0]    ok, hit_own, hit_oth, own_v, oth_v;
    src_t          stored [2];
    ent_t          own_e [2];
    ent_t          oth_e [2];
    logic          same_id;
    logic          unused_aggr;

    assign unused_aggr = ^{req_i[0].aggr, req_i[1].aggr};

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] v);
        return (v == PW'(FIFO_DEPTH - 1)) ? '0 : v + 1'b1;
    endfunction

    // Per-port table lookup of the requested id
    always_comb begin
        same_id = (req_i[0].id_req == req_i[1].id_req);
        for (int p = 0; p < 2; p++) begin
            ok[p]      = req_i[p].sync && req_i[p].aggr[0] &&
                         (32'(req_i[p].id_req) < N_BARRIERS);
            hit_own[p] = 1'b0;
            hit_oth[p] = 1'b0;
            stored[p]  = '0;
            for (int k = 0; k < N_BARRIERS; k++) begin
                if (req_i[p].id_req == ID_WIDTH'(k)) begin
                    hit_own[p] = arr_q[k][p];
                    hit_oth[p] = arr_q[k][1-p];
                    stored[p]  = src_q[k][1-p];
                end
            end
        end
    end

    always_comb begin
        arr_d = arr_q;
        src_d = src_q;
        own_v = '0;
        oth_v = '0;
        own_e = '{default: '0};
        oth_e = '{default: '0};
        for (int p = 0; p < 2; p++) begin
            if (req_i[p].sync) begin
                if (!ok[p] || hit_own[p]) begin
                    own_v[p] = 1'b1;
                    own_e[p] = '{dst: req_i[p].src, error: 1'b1};
                end else if (hit_oth[p]) begin
                    own_v[p]   = 1'b1;
                    own_e[p]   = '{dst: req_i[p].src, error: 1'b0};
                    oth_v[1-p] = 1'b1;
                    oth_e[1-p] = '{dst: stored[p], error: 1'b0};
                    for (int k = 0; k < N_BARRIERS; k++) begin
                        if (req_i[p].id_req == ID_WIDTH'(k)) begin
                            arr_d[k] = 2'b00;
                        end
                    end
                end else if (ok[1-p] && same_id) begin
                    // Both sides arrive together: each port wakes with its own src
                    own_v[p] = 1'b1;
                    own_e[p] = '{dst: req_i[p].src, error: 1'b0};
                end else begin
                    for (int k = 0; k < N_BARRIERS; k++) begin
                        if (req_i[p].id_req == ID_WIDTH'(k)) begin
                            arr_d[k][p] = 1'b1;
                            src_d[k][p] = req_i[p].src;
                        end
                    end
                end
            end
        end
    end

    // Pop frees a slot before the (up to two) pushes of the same cycle
    always_comb begin
        logic [CW-1:0] n;
        mem_d  = mem_q;
        wr_d   = wr_q;
        rd_d   = rd_q;
        cnt_d  = cnt_q;
        wake_d = '0;
        out_d  = '{default: '0};
        ovf_d  = ovf_q;
        n      = '0;
        for (int p = 0; p < 2; p++) begin
            n = cnt_q[p];
            if (n != '0) begin
                wake_d[p] = 1'b1;
                out_d[p]  = mem_q[p][rd_q[p]];
                rd_d[p]   = inc(rd_q[p]);
                n         = n - 1'b1;
            end
            if (oth_v[p]) begin
                if (n < CW'(FIFO_DEPTH)) begin
                    mem_d[p][wr_d[p]] = oth_e[p];
                    wr_d[p]           = inc(wr_d[p]);
                    n                 = n + 1'b1;
                end else begin
                    ovf_d[p] = 1'b1;
                end
            end
            if (own_v[p]) begin
                if (n < CW'(FIFO_DEPTH)) begin
                    mem_d[p][wr_d[p]] = own_e[p];
                    wr_d[p]           = inc(wr_d[p]);
                    n                 = n + 1'b1;
                end else begin
                    ovf_d[p] = 1'b1;
                end
            end
            cnt_d[p] = n;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            arr_q  <= '{default: '0};
            src_q  <= '{default: '0};
            mem_q  <= '{default: '0};
            wr_q   <= '{default: '0};
            rd_q   <= '{default: '0};
            cnt_q  <= '{default: '0};
            wake_q <= '0;
            out_q  <= '{default: '0};
            ovf_q  <= '0;
        end else begin
            arr_q  <= arr_d;
            src_q  <= src_d;
            mem_q  <= mem_d;
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            cnt_q  <= cnt_d;
            wake_q <= wake_d;
            out_q  <= out_d;
            ovf_q  <= ovf_d;
        end
    end

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rsp_o[p]       = '0;
            rsp_o[p].wake  = wake_q[p];
            rsp_o[p].dst   = out_q[p].dst;
            rsp_o[p].error = out_q[p].error;
        end
    end

    assign overflow_o = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_fractal_sync_root_rsp.sv
`default_nettype none
// ============================================================================
// Module   : tb_fractal_sync_root_rsp
// Brief    : Randomised and directed bench for fractal_sync_root_rsp with a
//            queue-based reference model.
// Revision : 1.0
// ============================================================================
module tb_fractal_sync_root_rsp;

    localparam int AW = 6;
    localparam int IW = 5;
    localparam int SW = 4;
    localparam int NB = 8;
    localparam int FD = 4;

    typedef struct packed {
        logic          sync;
        logic [AW-1:0] aggr;
        logic [IW-1:0] id_req;
        logic [SW-1:0] src;
    } req_t;

    typedef struct packed {
        logic          wake;
        logic [SW-1:0] dst;
        logic          error;
    } rsp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    req_t       req [2];
    rsp_t       rsp [2];
    logic [1:0] ovf;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fractal_sync_root_rsp #(
        .AGGREGATE_WIDTH(AW),
        .ID_WIDTH       (IW),
        .SRC_WIDTH      (SW),
        .N_BARRIERS     (NB),
        .FIFO_DEPTH     (FD),
        .fsync_req_t    (req_t),
        .fsync_rsp_t    (rsp_t)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .req_i     (req),
        .rsp_o     (rsp),
        .overflow_o(ovf)
    );

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit          m_arr  [NB][2];
    bit          snap   [NB][2];
    bit [SW-1:0] m_src  [NB][2];
    bit [SW:0]   q0 [$];
    bit [SW:0]   q1 [$];
    bit [1:0]    m_ovf;
    bit          e_wake [2];
    bit [SW:0]   e_ent  [2];
    bit          m_ok   [2];
    int          m_id   [2];
    bit          own_v  [2];
    bit          oth_v  [2];
    bit [SW:0]   own_e  [2];
    bit [SW:0]   oth_e  [2];

    task automatic push(input int p, input bit [SW:0] e);
        if (p == 0) begin
            if (q0.size() < FD) q0.push_back(e); else m_ovf[0] = 1'b1;
        end else begin
            if (q1.size() < FD) q1.push_back(e); else m_ovf[1] = 1'b1;
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NB; k++) begin
                m_arr[k][0] = 0; m_arr[k][1] = 0;
                m_src[k][0] = 0; m_src[k][1] = 0;
            end
            q0.delete();
            q1.delete();
            m_ovf = 0;
            e_wake[0] = 0; e_wake[1] = 0;
            e_ent[0]  = 0; e_ent[1]  = 0;
        end else begin
            e_wake[0] = (q0.size() != 0);
            e_ent[0]  = (q0.size() != 0) ? q0.pop_front() : '0;
            e_wake[1] = (q1.size() != 0);
            e_ent[1]  = (q1.size() != 0) ? q1.pop_front() : '0;
            for (int p = 0; p < 2; p++) begin
                m_ok[p]  = req[p].sync && req[p].aggr[0] && (req[p].id_req < NB);
                m_id[p]  = int'(req[p].id_req);
                own_v[p] = 0; oth_v[p] = 0;
                own_e[p] = 0; oth_e[p] = 0;
            end
            snap = m_arr;
            for (int p = 0; p < 2; p++) begin
                if (req[p].sync) begin
                    if (!m_ok[p] || snap[m_id[p]][p]) begin
                        own_v[p] = 1; own_e[p] = {req[p].src, 1'b1};
                    end else if (snap[m_id[p]][1-p]) begin
                        own_v[p] = 1; own_e[p] = {req[p].src, 1'b0};
                        oth_v[1-p] = 1; oth_e[1-p] = {m_src[m_id[p]][1-p], 1'b0};
                        m_arr[m_id[p]][0] = 0; m_arr[m_id[p]][1] = 0;
                    end else if (m_ok[1-p] && m_id[1-p] == m_id[p]) begin
                        own_v[p] = 1; own_e[p] = {req[p].src, 1'b0};
                    end else begin
                        m_arr[m_id[p]][p] = 1; m_src[m_id[p]][p] = req[p].src;
                    end
                end
            end
            for (int p = 0; p < 2; p++) begin
                if (oth_v[p]) push(p, oth_e[p]);
                if (own_v[p]) push(p, own_e[p]);
            end
        end
        #1;
        check("model rsp0", rsp[0], {e_wake[0], e_ent[0]});
        check("model rsp1", rsp[1], {e_wake[1], e_ent[1]});
        check("model ovf",  ovf,    m_ovf);
    end

    // ---------------- stimulus helpers ----------------
    function automatic req_t mk(input bit [AW-1:0] ag, input int id, input int sr);
        return req_t'({1'b1, ag, IW'(id), SW'(sr)});
    endfunction

    function automatic logic [5:0] rs(input bit w, input int d, input bit e);
        return {w, SW'(d), e};
    endfunction

    task automatic drive(input req_t a, input req_t b);
        @(negedge clk);
        req[0] = a;
        req[1] = b;
        @(negedge clk);
        req[0] = '0;
        req[1] = '0;
    endtask

    task automatic edge_chk(input string nm, input logic [5:0] r0, input logic [5:0] r1);
        @(posedge clk);
        #2;
        check({nm, " rsp0"}, rsp[0], r0);
        check({nm, " rsp1"}, rsp[1], r1);
    endtask

    task automatic pulse_rst();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    localparam req_t IDLE = '0;

    initial begin
        req[0] = '0;
        req[1] = '0;
        repeat (2) @(posedge clk);
        #2;
        check("reset rsp0", rsp[0], 0);
        check("reset rsp1", rsp[1], 0);
        check("reset ovf",  ovf,    0);
        @(negedge clk);
        rst = 1'b0;

        // Late partner: wakes two edges after the completing request
        drive(mk(6'd1, 0, 2), IDLE);
        repeat (19) @(negedge clk);
        drive(IDLE, mk(6'd1, 0, 3));
        check("latency rsp0", rsp[0], 0);
        edge_chk("pair id0", rs(1, 2, 0), rs(1, 3, 0));
        edge_chk("pair id0 done", 0, 0);

        // Simultaneous arrival, twice
        for (int i = 0; i < 2; i++) begin
            drive(mk(6'd1, 3, 1), mk(6'd1, 3, 1));
            edge_chk("same cycle id3", rs(1, 1, 0), rs(1, 1, 0));
        end

        // Invalid requests: aggr[0]=0 and id out of range
        drive(mk(6'd0, 0, 5), mk(6'd1, NB, 6));
        edge_chk("invalid", rs(1, 5, 1), rs(1, 6, 1));
        drive(mk(6'd1, 0, 4), IDLE);
        edge_chk("no table change", 0, 0);
        drive(IDLE, mk(6'd1, 0, 7));
        edge_chk("id0 after invalid", rs(1, 4, 0), rs(1, 7, 0));

        // Double arrival on port 1
        drive(IDLE, mk(6'd1, 4, 7));
        drive(IDLE, mk(6'd1, 4, 9));
        edge_chk("double arrival", 0, rs(1, 9, 1));
        drive(mk(6'd1, 4, 10), IDLE);
        edge_chk("keeps first src", rs(1, 10, 0), rs(1, 7, 0));

        // Completion plus invalid on the other port in one cycle
        drive(IDLE, mk(6'd1, 1, 4));
        drive(mk(6'd1, 1, 2), mk(6'd0, 1, 11));
        edge_chk("wake first", rs(1, 2, 0), rs(1, 4, 0));
        edge_chk("error second", 0, rs(1, 11, 1));
        check("no overflow", ovf, 2'b00);

        // Reset discards a half barrier
        drive(mk(6'd1, 2, 3), IDLE);
        pulse_rst();
        drive(IDLE, mk(6'd1, 2, 5));
        for (int i = 0; i < 3; i++) edge_chk("discarded", 0, 0);
        drive(mk(6'd1, 2, 6), IDLE);
        edge_chk("port1 waiting", rs(1, 6, 0), rs(1, 5, 0));

        // Two entries per cycle into port 0 overflow its FIFO
        for (int k = 0; k < NB; k++) drive(mk(6'd1, k, k), IDLE);
        for (int k = 0; k < NB; k++) begin
            @(negedge clk);
            req[0] = mk(6'd0, 0, 15);
            req[1] = mk(6'd1, k, k);
        end
        @(negedge clk);
        req[0] = '0;
        req[1] = '0;
        repeat (12) @(negedge clk);
        check("overflow sticky", ovf, 2'b01);
        pulse_rst();
        #1;
        check("overflow cleared", ovf, 2'b00);

        // Randomised traffic with occasional reset
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 399) == 0);
            for (int p = 0; p < 2; p++) begin
                if ($urandom_range(0, 1) == 1)
                    req[p] = mk({5'($urandom), 1'($urandom_range(0, 7) != 0)},
                                $urandom_range(0, NB), $urandom_range(0, 15));
                else
                    req[p] = '0;
            end
        end
        @(negedge clk);
        rst = 1'b0;
        req[0] = '0;
        req[1] = '0;
        repeat (10) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
